// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: the fetch side raises imem_req with imem_addr and holds both stable until the
// memory answers with imem_ack for one cycle; imem_rdata is only meaningful on that cycle.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction memory and buffers
// them with their PC+4 in a small prefetch queue whose head feeds the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  imem,
    input  logic          IFID_write,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    output logic [31:0]   ins_out,
    output logic [31:0]   pc_out,
    output logic          IF_flush,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]    state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [31:0]   req_addr, req_addr_n;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_n;
    logic [63:0]   q_mem [FIFO_DEPTH];
    logic          push, pop, space;

    // A redirect overrides any push or pop on the same edge.
    assign push    = (state == ST_REQ) && imem.imem_ack && !branch_taken;
    assign pop     = IFID_write && (count != '0) && !branch_taken;
    assign count_n = branch_taken ? '0 : (count + CW'(push) - CW'(pop));
    assign space   = (count_n < CW'(FIFO_DEPTH));

    assign imem.imem_req  = (state != ST_IDLE);
    assign imem.imem_addr = req_addr;
    assign IF_flush       = branch_taken & ~reset;
    assign dbg_state      = state;
    assign {ins_out, pc_out} = (count != '0) ? q_mem[rd_ptr] : 64'd0;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_addr_n = req_addr;
        case (state)
            ST_IDLE: begin
                if (branch_taken) begin
                    state_n    = ST_REQ;
                    fetch_pc_n = branch_target;
                    req_addr_n = branch_target;
                end else if (space) begin
                    state_n    = ST_REQ;
                    req_addr_n = fetch_pc;
                end
            end
            ST_REQ: begin
                if (branch_taken) begin
                    fetch_pc_n = branch_target;
                    if (imem.imem_ack) begin
                        req_addr_n = branch_target;
                    end else begin
                        state_n = ST_DROP;
                    end
                end else if (imem.imem_ack) begin
                    fetch_pc_n = req_addr + 32'd4;
                    if (space) begin
                        req_addr_n = req_addr + 32'd4;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                // The stale request must complete on the bus before the target is fetched.
                if (branch_taken) begin
                    fetch_pc_n = branch_target;
                end
                if (imem.imem_ack) begin
                    state_n    = ST_REQ;
                    req_addr_n = branch_taken ? branch_target : fetch_pc;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_addr <= req_addr_n;
            count    <= count_n;
            if (branch_taken) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push) wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= {imem.imem_rdata, req_addr + 32'd4};
        end
    end

    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (imem.imem_req && !imem.imem_ack) |=> (imem.imem_req && $stable(imem.imem_addr)));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        push |-> (count < CW'(FIFO_DEPTH) || pop));

endmodule
